// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: register-address width, link register index,
// and the RegDst encoding used by the destination selector.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int LINK_REG   = 31;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    REGDST_RT = 1'b0,
    REGDST_RD = 1'b1
  } regdst_e;

endpackage

// File: rtl/mux_before_register_file_dest_pipe_reg.sv
// One-stage destination pipeline register with reset > flush > stall > load priority.
// Reset and flush both clear the stage; stall holds it.
module dest_pipe_reg
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_stall,
  input  logic      i_flush,
  input  reg_addr_t i_addr,
  input  logic      i_valid,
  input  logic      i_write,
  output reg_addr_t o_addr,
  output logic      o_valid,
  output logic      o_write
);

  reg_addr_t r_addr;
  logic      r_valid;
  logic      r_write;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_write <= 1'b0;
    end else if (!i_stall) begin
      r_addr  <= i_addr;
      r_valid <= i_valid;
      r_write <= i_write;
    end
  end

  assign o_addr  = r_addr;
  assign o_valid = r_valid;
  assign o_write = r_write;

endmodule

// File: rtl/mux_before_register_file.sv
// Destination-register selector (rt/rd by RegDst) feeding the register-file write port,
// plus a registered copy for write-back. Optional JAL/JALR link override: MUX_REG_FILE_LINK_EN.
module mux_before_register_file
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      RegDst,
  input  reg_addr_t rt,
  input  reg_addr_t rd,
`ifdef MUX_REG_FILE_LINK_EN
  input  logic      Link,
`endif
  // in_valid marks a decoded instruction this cycle; there is no ready, the
  // stage accepts every cycle unless stall holds it or flush squashes it.
  input  logic      in_valid,
  input  logic      reg_write_in,
  input  logic      stall,
  input  logic      flush,
  output reg_addr_t WriteRegister,
  output reg_addr_t write_register_q,
  output logic      reg_write_q,
  output logic      valid_q,
  output logic      zero_dest
);

  reg_addr_t w_sel;
  logic      w_zero;
  logic      w_write_qual;

  always_comb begin
    w_sel = (regdst_e'(RegDst) == REGDST_RD) ? rd : rt;
`ifdef MUX_REG_FILE_LINK_EN
    if (Link) w_sel = reg_addr_t'(LINK_REG);
`endif
  end

  // $zero is hardwired, so a write to it is never presented downstream.
  assign w_zero       = (w_sel == '0);
  assign w_write_qual = reg_write_in & in_valid & ~w_zero;

  assign WriteRegister = w_sel;
  assign zero_dest     = w_zero;

  dest_pipe_reg u_dest_pipe_reg (
    .clk     (clk),
    .reset   (reset),
    .i_stall (stall),
    .i_flush (flush),
    .i_addr  (w_sel),
    .i_valid (in_valid),
    .i_write (w_write_qual),
    .o_addr  (write_register_q),
    .o_valid (valid_q),
    .o_write (reg_write_q)
  );

endmodule

// File: tb/tb_mux_before_register_file.sv
// Self-checking bench for mux_before_register_file: directed steps followed by
// randomized steps checked against a behavioural model of the destination stage.
module tb_mux_before_register_file;

  logic       clk;
  logic       reset;
  logic       RegDst;
  logic [4:0] rt;
  logic [4:0] rd;
`ifdef MUX_REG_FILE_LINK_EN
  logic       Link;
`endif
  logic       in_valid;
  logic       reg_write_in;
  logic       stall;
  logic       flush;
  logic [4:0] WriteRegister;
  logic [4:0] write_register_q;
  logic       reg_write_q;
  logic       valid_q;
  logic       zero_dest;

  int checks;
  int failures;

  // Behavioural model of the write-back stage contents.
  logic [4:0] m_addr;
  logic       m_valid;
  logic       m_write;

  mux_before_register_file dut (
    .clk              (clk),
    .reset            (reset),
    .RegDst           (RegDst),
    .rt               (rt),
    .rd               (rd),
`ifdef MUX_REG_FILE_LINK_EN
    .Link             (Link),
`endif
    .in_valid         (in_valid),
    .reg_write_in     (reg_write_in),
    .stall            (stall),
    .flush            (flush),
    .WriteRegister    (WriteRegister),
    .write_register_q (write_register_q),
    .reg_write_q      (reg_write_q),
    .valid_q          (valid_q),
    .zero_dest        (zero_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] model_dest();
    logic [4:0] d;
    d = RegDst ? rd : rt;
`ifdef MUX_REG_FILE_LINK_EN
    if (Link) d = 5'd31;
`endif
    return d;
  endfunction

  task automatic check_comb(input string tag);
    logic [4:0] e;
    e = model_dest();
    checks++;
    assert (WriteRegister === e) else begin
      failures++;
      $error("FAIL %s WriteRegister got=%0d exp=%0d", tag, WriteRegister, e);
    end
    checks++;
    assert (zero_dest === (e == 5'd0)) else begin
      failures++;
      $error("FAIL %s zero_dest got=%0b exp=%0b", tag, zero_dest, (e == 5'd0));
    end
  endtask

  task automatic check_regs(input string tag);
    checks++;
    assert (write_register_q === m_addr) else begin
      failures++;
      $error("FAIL %s write_register_q got=%0d exp=%0d", tag, write_register_q, m_addr);
    end
    checks++;
    assert (reg_write_q === m_write) else begin
      failures++;
      $error("FAIL %s reg_write_q got=%0b exp=%0b", tag, reg_write_q, m_write);
    end
    checks++;
    assert (valid_q === m_valid) else begin
      failures++;
      $error("FAIL %s valid_q got=%0b exp=%0b", tag, valid_q, m_valid);
    end
  endtask

  // Drive one cycle of inputs, check combinational outputs, clock, check registers.
  task automatic step(input string tag, input logic rst, input logic rdst,
                      input logic [4:0] a_rt, input logic [4:0] a_rd,
                      input logic v, input logic w, input logic st, input logic fl);
    logic [4:0] d;
    reset = rst; RegDst = rdst; rt = a_rt; rd = a_rd;
    in_valid = v; reg_write_in = w; stall = st; flush = fl;
    #1;
    check_comb(tag);
    d = model_dest();
    if (rst || fl) begin
      m_addr = 5'd0; m_valid = 1'b0; m_write = 1'b0;
    end else if (!st) begin
      m_addr  = d;
      m_valid = v;
      m_write = w && v && (d != 5'd0);
    end
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  initial begin
    checks = 0; failures = 0;
    m_addr = '0; m_valid = 1'b0; m_write = 1'b0;
`ifdef MUX_REG_FILE_LINK_EN
    Link = 1'b0;
`endif
    reset = 1'b1; RegDst = 1'b0; rt = '0; rd = '0;
    in_valid = 1'b0; reg_write_in = 1'b0; stall = 1'b0; flush = 1'b0;

    // Combinational select with no clock edge in between.
    RegDst = 1'b1; rt = 5'd4; rd = 5'd6;
    #1;
    check_comb("sel_rd");
    RegDst = 1'b0;
    #1;
    check_comb("sel_rt");

    // Reset for two cycles with arbitrary inputs.
    step("reset0", 1'b1, 1'b1, 5'd7, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0);
    step("reset1", 1'b1, 1'b0, 5'd3, 5'd22, 1'b1, 1'b1, 1'b1, 1'b0);
    step("load_rd9", 1'b0, 1'b1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    step("zero_dest", 1'b0, 1'b0, 5'd0, 5'd17, 1'b1, 1'b1, 1'b0, 1'b0);
    step("invalid_cap", 1'b0, 1'b1, 5'd1, 5'd25, 1'b0, 1'b1, 1'b0, 1'b0);

    // Stall holds a loaded rd=12 while rd moves to 20.
    step("load_rd12", 1'b0, 1'b1, 5'd1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("stall_hold", 1'b0, 1'b1, 5'd1, 5'd20, 1'b1, 1'b1, 1'b1, 1'b0);
    step("stall_release", 1'b0, 1'b1, 5'd1, 5'd20, 1'b1, 1'b1, 1'b0, 1'b0);

    // Flush beats stall; reset clears during a stall.
    step("stall_flush", 1'b0, 1'b1, 5'd1, 5'd14, 1'b1, 1'b1, 1'b1, 1'b1);
    step("reload", 1'b0, 1'b0, 5'd30, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step("reset_in_stall", 1'b1, 1'b0, 5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);

`ifdef MUX_REG_FILE_LINK_EN
    Link = 1'b1;
    step("link", 1'b0, 1'b1, 5'd3, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    Link = 1'b0;
`endif

    for (int i = 0; i < 300; i++) begin
`ifdef MUX_REG_FILE_LINK_EN
      Link = ($urandom_range(0, 7) == 0);
`endif
      step("random",
           ($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
           ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
